// File: rtl/if_stage.sv
// Instruction-fetch stage: owns the PC, issues one fetch at a time to the
// instruction port and holds the fetched {pc, inst} until IF/ID accepts it.
module if_stage #(
  parameter logic [31:0] RESET_PC = 32'h8000_0000,
  parameter int unsigned PC_STEP  = 4
) (
  input  logic        clk_i,
  input  logic        rst_ni,
  input  logic        ctl_jbr_taken_i,
  input  logic [31:0] jbr_target_i,
  input  logic        ctl_baseram_hazard_i,
  input  logic        ctl_id_allow_in_i,
  output logic        inst_req_o,
  output logic [31:0] inst_addr_o,
  input  logic        inst_rvalid_i,
  input  logic [31:0] inst_rdata_i,
  output logic [31:0] if_pc_o,
  output logic [31:0] if_inst_o,
  output logic        ctl_if_over_o
);

  localparam int unsigned XLEN = 32;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_FETCH = 2'd1,
    S_HOLD  = 2'd2
  } state_e;

  state_e           state_q, state_d;
  logic [XLEN-1:0]  pc_q, pc_d;
  logic [XLEN-1:0]  if_pc_q, if_pc_d;
  logic [XLEN-1:0]  if_inst_q, if_inst_d;
  logic             if_over_q, if_over_d;
  logic             fetch_req;
  logic             accept;

  // State and datapath registers; async reset abandons any outstanding fetch.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q   <= S_IDLE;
      pc_q      <= RESET_PC;
      if_pc_q   <= '0;
      if_inst_q <= '0;
      if_over_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      pc_q      <= pc_d;
      if_pc_q   <= if_pc_d;
      if_inst_q <= if_inst_d;
      if_over_q <= if_over_d;
    end
  end

  // Next state: redirect wins over everything, then capture/accept per state.
  always_comb begin
    state_d   = state_q;
    pc_d      = pc_q;
    if_pc_d   = if_pc_q;
    if_inst_d = if_inst_q;
    if_over_d = if_over_q;
    if (ctl_jbr_taken_i) begin
      // Low target bits are forced to zero; any same-cycle response is dropped.
      pc_d      = jbr_target_i & ~XLEN'(3);
      if_over_d = 1'b0;
      state_d   = S_FETCH;
    end else begin
      unique case (state_q)
        S_IDLE: begin
          state_d = S_FETCH;
        end
        S_FETCH: begin
          // A response only counts while the request is actually on the bus.
          if (fetch_req && inst_rvalid_i) begin
            if_inst_d = inst_rdata_i;
            if_pc_d   = pc_q;
            if_over_d = 1'b1;
            state_d   = S_HOLD;
          end
        end
        S_HOLD: begin
          if (accept) begin
            pc_d      = pc_q + XLEN'(PC_STEP);
            if_over_d = 1'b0;
            state_d   = S_FETCH;
          end
        end
        default: begin
          state_d = S_IDLE;
        end
      endcase
    end
  end

  // Outputs: request is gated by the data-side bus ownership.
  always_comb begin
    fetch_req = (state_q == S_FETCH) && !ctl_baseram_hazard_i;
    accept    = (state_q == S_HOLD) && !ctl_baseram_hazard_i &&
                ctl_id_allow_in_i && !ctl_jbr_taken_i;
  end

  assign inst_req_o    = fetch_req;
  assign inst_addr_o   = pc_q;
  assign if_pc_o       = if_pc_q;
  assign if_inst_o     = if_inst_q;
  assign ctl_if_over_o = if_over_q;

endmodule

// File: tb/tb_if_stage.sv
// Bench for if_stage: directed scenarios followed by random traffic, checked
// against a program-order model of which {pc, inst} IF/ID should receive.
module tb_if_stage;

  localparam logic [31:0] RST_PC  = 32'h8000_0000;
  localparam logic [31:0] WRAP_PC = 32'hFFFF_FFFC;

  logic        clk;
  logic        rst_n;
  logic        jbr;
  logic [31:0] target;
  logic        hazard;
  logic        allow;
  logic        req;
  logic [31:0] addr;
  logic        rvalid;
  logic [31:0] rdata;
  logic [31:0] if_pc;
  logic [31:0] if_inst;
  logic        over;

  logic        req2;
  logic [31:0] addr2;
  logic [31:0] if_pc2;
  logic [31:0] if_inst2;
  logic        over2;

  int checks = 0;
  int errors = 0;

  // Instruction memory content as a pure function of the address.
  function automatic logic [31:0] mem_fn(input logic [31:0] a);
    return (a * 32'd2654435761) ^ 32'h0000_0013;
  endfunction

  // While the data side owns the bus the port returns garbage.
  assign rdata = hazard ? 32'hDEAD_BEEF : mem_fn(addr);

  if_stage #(.RESET_PC(RST_PC), .PC_STEP(4)) dut (
    .clk_i(clk), .rst_ni(rst_n),
    .ctl_jbr_taken_i(jbr), .jbr_target_i(target),
    .ctl_baseram_hazard_i(hazard), .ctl_id_allow_in_i(allow),
    .inst_req_o(req), .inst_addr_o(addr),
    .inst_rvalid_i(rvalid), .inst_rdata_i(rdata),
    .if_pc_o(if_pc), .if_inst_o(if_inst), .ctl_if_over_o(over)
  );

  if_stage #(.RESET_PC(WRAP_PC), .PC_STEP(4)) dut_wrap (
    .clk_i(clk), .rst_ni(rst_n),
    .ctl_jbr_taken_i(1'b0), .jbr_target_i(32'h0),
    .ctl_baseram_hazard_i(1'b0), .ctl_id_allow_in_i(1'b1),
    .inst_req_o(req2), .inst_addr_o(addr2),
    .inst_rvalid_i(1'b1), .inst_rdata_i(32'h0),
    .if_pc_o(if_pc2), .if_inst_o(if_inst2), .ctl_if_over_o(over2)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h expected=%h", name, act, exp);
    end
  endtask

  // Scoreboard state: redirect targets issued by the driver, consumed by the monitor.
  logic [31:0] redir_q[$];
  logic [31:0] exp_pc;
  bit          mon_en   = 1'b0;
  bit          prev_jbr = 1'b0;
  int          cyc      = 0;
  int          accepts  = 0;
  int          acc_cyc[$];

  // Monitor: next instruction IF/ID receives is last accepted pc + 4, or the
  // most recent redirect target if one happened since.
  always @(negedge clk) begin
    logic [31:0] t;
    cyc++;
    if (mon_en) begin
      if (hazard) check("req_gated_by_hazard", 32'(req), 32'd0);
      if (req) check("fetch_addr", addr, exp_pc);
      if (over) begin
        check("hold_no_req", 32'(req), 32'd0);
        check("held_pc", if_pc, exp_pc);
        check("held_inst", if_inst, mem_fn(exp_pc));
      end
      if (prev_jbr) check("redirect_drops_over", 32'(over), 32'd0);
      if (over && allow && !hazard && !jbr) begin
        accepts++;
        acc_cyc.push_back(cyc);
        exp_pc = exp_pc + 32'd4;
      end
      if (redir_q.size() > 0) begin
        t = redir_q[redir_q.size()-1];
        exp_pc = {t[31:2], 2'b00};
        redir_q.delete();
      end
      prev_jbr = jbr;
    end
  end

  // Wrap-around instance: record its first fetch addresses and delivered pcs.
  logic [31:0] wrap_addrs[$];
  logic [31:0] wrap_exp = WRAP_PC;
  bit          wrap_mon = 1'b0;
  always @(negedge clk) begin
    if (wrap_mon) begin
      if (req2 && wrap_addrs.size() < 2) wrap_addrs.push_back(addr2);
      if (over2 && wrap_exp != 32'h8) begin
        check("wrap_if_pc", if_pc2, wrap_exp);
        check("wrap_if_inst", if_inst2, 32'h0);
        wrap_exp = wrap_exp + 32'd4;
      end
    end
  end

  task automatic issue_redirect(input logic [31:0] tgt);
    jbr    = 1'b1;
    target = tgt;
    redir_q.push_back(tgt);
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    logic [31:0] hp;
    int          n;
    rst_n  = 1'b0;
    jbr    = 1'b0;
    target = '0;
    hazard = 1'b0;
    allow  = 1'b0;
    rvalid = 1'b0;
    repeat (2) step();

    // Reset values
    check("rst_req", 32'(req), 32'd0);
    check("rst_over", 32'(over), 32'd0);
    check("rst_if_pc", if_pc, 32'd0);
    check("rst_if_inst", if_inst, 32'd0);
    check("rst_addr", addr, RST_PC);

    // Streaming: response same cycle as request, IF/ID always ready
    rvalid   = 1'b1;
    allow    = 1'b1;
    exp_pc   = RST_PC;
    rst_n    = 1'b1;
    mon_en   = 1'b1;
    wrap_mon = 1'b1;
    @(negedge clk);
    check("idle_dead_cycle", 32'(req), 32'd0);
    @(negedge clk);
    check("first_req", 32'(req), 32'd1);
    check("first_addr", addr, RST_PC);
    repeat (8) step();
    check("stream_accepts", 32'(acc_cyc.size() >= 3), 32'd1);
    for (int i = 1; i < acc_cyc.size(); i++)
      check("stream_rate", 32'(acc_cyc[i] - acc_cyc[i-1]), 32'd2);

    // HOLD with IF/ID stalled for three cycles
    allow = 1'b0;
    n = 0;
    while (!over && n < 10) begin step(); n++; end
    check("hold_reached", 32'(over), 32'd1);
    hp = exp_pc;
    repeat (3) begin
      step();
      check("hold_over", 32'(over), 32'd1);
      check("hold_pc_frozen", if_pc, hp);
      check("hold_inst_frozen", if_inst, mem_fn(hp));
      check("hold_req_low", 32'(req), 32'd0);
    end
    allow = 1'b1;
    step();
    allow = 1'b0;
    check("after_accept_req", 32'(req), 32'd1);
    check("after_accept_addr", addr, hp + 32'd4);

    // Hazard while fetching: bus garbage must be ignored
    hazard = 1'b1;
    repeat (3) begin
      step();
      check("hazard_req_low", 32'(req), 32'd0);
      check("hazard_no_capture", 32'(over), 32'd0);
    end
    hazard = 1'b0;
    #1;
    check("rerequest_req", 32'(req), 32'd1);
    check("rerequest_addr", addr, hp + 32'd4);
    step();
    check("post_hazard_capture", 32'(over), 32'd1);
    check("post_hazard_inst", if_inst, mem_fn(hp + 32'd4));

    // Redirect while holding: held instruction dropped
    issue_redirect(32'h8000_0123);
    step();
    jbr    = 1'b0;
    rvalid = 1'b0;
    check("jbr_hold_over", 32'(over), 32'd0);
    check("jbr_hold_req", 32'(req), 32'd1);
    check("jbr_hold_addr", addr, 32'h8000_0120);
    step();

    // Redirect in the same cycle as a memory response
    rvalid = 1'b1;
    issue_redirect(32'h0000_1000);
    step();
    jbr    = 1'b0;
    rvalid = 1'b0;
    check("jbr_rvalid_over", 32'(over), 32'd0);
    check("jbr_rvalid_addr", addr, 32'h0000_1000);
    step();
    check("jbr_rvalid_no_pulse", 32'(over), 32'd0);

    // Random traffic
    for (int i = 0; i < 800; i++) begin
      hazard = ($urandom % 4) == 0;
      rvalid = ($urandom % 3) != 0;
      allow  = ($urandom % 4) != 0;
      jbr    = 1'b0;
      if (($urandom % 14) == 0) issue_redirect($urandom);
      step();
    end

    // Async reset mid-fetch
    jbr    = 1'b0;
    hazard = 1'b0;
    rvalid = 1'b0;
    allow  = 1'b1;
    repeat (3) step();
    check("pre_reset_req", 32'(req), 32'd1);
    #1;
    mon_en = 1'b0;
    rst_n  = 1'b0;
    #1;
    check("async_rst_req", 32'(req), 32'd0);
    check("async_rst_over", 32'(over), 32'd0);
    check("async_rst_if_pc", if_pc, 32'd0);
    check("async_rst_if_inst", if_inst, 32'd0);
    check("async_rst_addr", addr, RST_PC);
    step();
    redir_q.delete();
    exp_pc   = RST_PC;
    prev_jbr = 1'b0;
    rvalid   = 1'b1;
    n        = accepts;
    rst_n    = 1'b1;
    mon_en   = 1'b1;
    repeat (12) step();
    check("post_reset_progress", 32'(accepts - n >= 4), 32'd1);
    check("total_progress", 32'(accepts >= 100), 32'd1);

    check("wrap_addr_count", 32'(wrap_addrs.size()), 32'd2);
    if (wrap_addrs.size() == 2) begin
      check("wrap_first_addr", wrap_addrs[0], WRAP_PC);
      check("wrap_second_addr", wrap_addrs[1], 32'h0000_0000);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
